// File: rtl/aes_reg_sequencer.sv
// AES-128 register-file sequencer: gathers 4 data and 4 key words, runs the
// external AES/invAES core for a fixed latency and writes the 4 result words back.
module aes_reg_sequencer #(
   parameter int AES_LATENCY = 12,
   parameter int REG_AW      = 5
) (
   input  logic              RST,
   input  logic              CLK_DC,
   input  logic              start,
   input  logic              mode,
   input  logic [REG_AW-1:0] src_base,
   input  logic [REG_AW-1:0] key_base,
   input  logic [REG_AW-1:0] dst_base,
   output logic              reg_req,
   input  logic              reg_gnt,
   output logic [REG_AW-1:0] ra,
   input  logic [31:0]       rd,
   output logic [REG_AW-1:0] wa,
   output logic [31:0]       wd,
   output logic              we,
   output logic [127:0]      aes_data,
   output logic [127:0]      aes_key,
   output logic              aes_sel_inv,
   input  logic [127:0]      aes_result,
   output logic              busy,
   output logic              done,
   output logic              stall
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_GNT  = 3'd1;
   localparam logic [2:0] S_LOAD      = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_WAIT_GNT2 = 3'd4;
   localparam logic [2:0] S_WRITE     = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   logic [2:0]        state_q, state_d;
   logic              mode_q, mode_d;
   logic [REG_AW-1:0] src_q, src_d, kb_q, kb_d, dst_q, dst_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic [7:0]        run_q, run_d;
   logic [127:0]      data_q, data_d, key_q, key_d, res_q, res_d;

   logic              issue, wr_go;
   logic [REG_AW-1:0] rd_addr, wr_addr;
   logic [2:0]        cap_idx;
   logic [31:0]       wr_word;

   always_comb begin
      issue   = (state_q == S_LOAD) && reg_gnt && (cnt_q < 4'd8);
      wr_go   = (state_q == S_WRITE) && reg_gnt;
      rd_addr = (cnt_q[2] ? kb_q : src_q) + REG_AW'(cnt_q[1:0]);
      wr_addr = dst_q + REG_AW'(cnt_q[1:0]);
      // the word returning this cycle was issued when cnt was one lower
      cap_idx = 3'(cnt_q - 4'd1);
      case (cnt_q[1:0])
         2'd0:    wr_word = res_q[127:96];
         2'd1:    wr_word = res_q[95:64];
         2'd2:    wr_word = res_q[63:32];
         default: wr_word = res_q[31:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      src_d     = src_q;
      kb_d      = kb_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      data_d    = data_q;
      key_d     = key_q;
      res_d     = res_q;
      rd_pend_d = issue;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               src_d   = src_base;
               kb_d    = key_base;
               dst_d   = dst_base;
               cnt_d   = '0;
               state_d = S_WAIT_GNT;
            end
         end
         S_WAIT_GNT: begin
            if (reg_gnt) begin
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (issue) cnt_d = cnt_q + 4'd1;
            if (rd_pend_q) begin
               if (!cap_idx[2]) data_d[(3 - int'(cap_idx[1:0]))*32 +: 32] = rd;
               else             key_d[(3 - int'(cap_idx[1:0]))*32 +: 32]  = rd;
            end
            if (cnt_q == 4'd8) begin
               run_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (run_q == 8'(AES_LATENCY - 1)) begin
               res_d   = aes_result;
               cnt_d   = '0;
               state_d = S_WAIT_GNT2;
            end else begin
               run_d = run_q + 8'd1;
            end
         end
         S_WAIT_GNT2: begin
            if (reg_gnt) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (reg_gnt) begin
               if (cnt_q[1:0] == 2'd3) state_d = S_DONE;
               else                    cnt_d   = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_DC or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         src_q     <= '0;
         kb_q      <= '0;
         dst_q     <= '0;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         run_q     <= '0;
         data_q    <= '0;
         key_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         src_q     <= src_d;
         kb_q      <= kb_d;
         dst_q     <= dst_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         run_q     <= run_d;
         data_q    <= data_d;
         key_q     <= key_d;
         res_q     <= res_d;
      end
   end

   // register x0 is hardwired: its write slot is consumed without a strobe
   assign ra          = issue ? rd_addr : '0;
   assign wa          = wr_go ? wr_addr : '0;
   assign wd          = wr_go ? wr_word : '0;
   assign we          = wr_go && (wr_addr != '0);
   assign reg_req     = (state_q == S_WAIT_GNT) || (state_q == S_LOAD) ||
                        (state_q == S_WAIT_GNT2) || (state_q == S_WRITE);
   assign stall       = reg_req;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign aes_data    = data_q;
   assign aes_key     = key_q;
   assign aes_sel_inv = mode_q;

endmodule

// File: tb/tb_aes_reg_sequencer.sv
// Scoreboard bench: a register-file model and a latency-checking AES core model
// surround the sequencer; expected writes/done pulses are queued per operation.
module tb_aes_reg_sequencer;

   localparam int unsigned LAT    = 12;
   localparam int unsigned MINLAT = 1 + 9 + LAT + 1 + 4 + 1;
   localparam logic [127:0] PT  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

   logic         RST, CLK_DC, start, mode, reg_req, reg_gnt, we, aes_sel_inv, busy, done, stall;
   logic [4:0]   src_base, key_base, dst_base, ra, wa;
   logic [31:0]  rd, wd;
   logic [127:0] aes_data, aes_key, aes_result;

   aes_reg_sequencer #(.AES_LATENCY(LAT), .REG_AW(5)) dut (
      .RST(RST), .CLK_DC(CLK_DC), .start(start), .mode(mode),
      .src_base(src_base), .key_base(key_base), .dst_base(dst_base),
      .reg_req(reg_req), .reg_gnt(reg_gnt), .ra(ra), .rd(rd), .wa(wa), .wd(wd), .we(we),
      .aes_data(aes_data), .aes_key(aes_key), .aes_sel_inv(aes_sel_inv),
      .aes_result(aes_result), .busy(busy), .done(done), .stall(stall)
   );

   initial CLK_DC = 1'b0;
   always #5 CLK_DC = ~CLK_DC;

   int unsigned cyc = 0;
   always @(posedge CLK_DC) cyc <= cyc + 1;

   // register file with registered read; poke port preloads it while idle
   logic [31:0] mem [32];
   logic        poke_en;
   logic [4:0]  poke_a;
   logic [31:0] poke_d;
   always @(posedge CLK_DC) begin
      rd <= mem[ra];
      if (poke_en) mem[poke_a] <= poke_d;
      else if (we) mem[wa] <= wd;
   end

   function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k, input logic m);
      if (!m && k == KEY && d == PT) return CT;
      if (m && k == KEY && d == CT) return PT;
      return {d[119:0], d[127:120]} ^ {k[63:0], k[127:64]} ^
             (m ? {4{32'h5ac33ca5}} : 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
   endfunction

   // core output is only correct once operands have been stable for LAT cycles
   logic [127:0] snap_d = 'x, snap_k = 'x;
   logic         snap_m = 1'bx;
   int unsigned  stab = 0;
   always @(negedge CLK_DC) begin
      if (aes_data !== snap_d || aes_key !== snap_k || aes_sel_inv !== snap_m) begin
         snap_d = aes_data; snap_k = aes_key; snap_m = aes_sel_inv; stab = 0;
      end else if (stab < 1000) begin
         stab = stab + 1;
      end
      aes_result = (stab >= LAT - 1) ? core_f(aes_data, aes_key, aes_sel_inv) : {4{32'hbad0c0de}};
   end

   typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
   typedef struct { int unsigned lat; logic m; } dn_t;
   wr_t exp_wr[$];
   dn_t exp_dn[$];

   logic [31:0] shadow [32];
   logic [4:0]  last_a [4];
   logic [31:0] last_v [4];
   int unsigned checks = 0, errors = 0, wr_seen = 0, done_seen = 0, t0 = 0, gnt_mode = 0;

   function automatic logic [31:0] word(input logic [127:0] v, input int unsigned i);
      return v[127 - 32*i -: 32];
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge CLK_DC); #1;
         if (prev_done) begin
            chk("done_one_cycle", done, 1'b0);
            chk("idle_after_done", busy, 1'b0);
         end
         prev_done = done;
         if (we) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: actual wa=%0d wd=%h required no write", wa, wd);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("write_addr", wa, e.a);
               chk("write_data", wd, e.d);
            end
         end
         if (done) begin
            done_seen++;
            if (exp_dn.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: actual done=1 required done=0");
            end else begin
               dn_t e;
               e = exp_dn.pop_front();
               chk("sel_inv_at_done", aes_sel_inv, e.m);
               chk("busy_at_done", busy, 1'b1);
               chk("writes_drained", exp_wr.size(), 0);
               if (e.lat != 0) chk("done_latency", cyc + 1 - t0, e.lat);
            end
         end
      end
   endtask

   task automatic gnt_drv();
      forever begin
         @(negedge CLK_DC);
         case (gnt_mode)
            0:       reg_gnt = 1'b1;
            1:       reg_gnt = ~reg_gnt;
            default: reg_gnt = ($urandom_range(0, 2) != 0);
         endcase
      end
   endtask

   task automatic poke(input logic [4:0] a, input logic [31:0] v);
      @(negedge CLK_DC);
      poke_en = 1'b1; poke_a = a; poke_d = v; shadow[a] = v;
      @(posedge CLK_DC); #1;
      poke_en = 1'b0;
   endtask

   task automatic issue(input logic [4:0] s, input logic [4:0] k, input logic [4:0] d,
                        input logic m, input int unsigned lat);
      logic [127:0] dv, kv, rv;
      logic [4:0]   addr;
      dv = '0; kv = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         addr = s + 5'(i); dv = {dv[95:0], shadow[addr]};
         addr = k + 5'(i); kv = {kv[95:0], shadow[addr]};
      end
      rv = core_f(dv, kv, m);
      for (int unsigned i = 0; i < 4; i++) begin
         addr = d + 5'(i);
         last_a[i] = addr; last_v[i] = shadow[addr];
         if (addr != 5'd0) begin
            exp_wr.push_back('{a: addr, d: word(rv, i)});
            shadow[addr] = word(rv, i);
         end
      end
      exp_dn.push_back('{lat: lat, m: m});
      @(negedge CLK_DC);
      start = 1'b1; mode = m; src_base = s; key_base = k; dst_base = d;
      @(posedge CLK_DC); #1;
      t0 = cyc;
      start = 1'b0; mode = 1'($urandom);
      src_base = 5'($urandom); key_base = 5'($urandom); dst_base = 5'($urandom);
   endtask

   task automatic wait_done();
      int unsigned n0, g;
      n0 = done_seen; g = 0;
      while (done_seen == n0 && g < 1000) begin
         @(posedge CLK_DC); g++;
      end
      chk("done_seen", done_seen != n0, 1'b1);
      repeat (3) @(posedge CLK_DC);
   endtask

   task automatic load_pt(input logic [127:0] v);
      for (int unsigned i = 0; i < 4; i++) poke(5'(4 + i), word(v, i));
   endtask

   initial begin
      int unsigned n0, g;
      RST = 1'b0; start = 1'b0; mode = 1'b0; src_base = '0; key_base = '0; dst_base = '0;
      reg_gnt = 1'b1; poke_en = 1'b0; poke_a = '0; poke_d = '0;
      fork
         monitor();
         gnt_drv();
      join_none

      repeat (3) @(posedge CLK_DC); #1;
      chk("reset_ctrl", {reg_req, ra, wa, wd, we, aes_sel_inv, busy, done, stall}, '0);
      chk("reset_aes_data", aes_data, '0);
      chk("reset_aes_key", aes_key, '0);
      @(negedge CLK_DC); RST = 1'b1;

      for (int unsigned i = 0; i < 32; i++) poke(5'(i), (i == 0) ? 32'h0 : $urandom);
      load_pt(PT);
      for (int unsigned i = 0; i < 4; i++) poke(5'(8 + i), word(KEY, i));

      // FIPS-197 encrypt then decrypt
      issue(5'd4, 5'd8, 5'd12, 1'b0, MINLAT); wait_done();
      for (int unsigned i = 0; i < 4; i++) chk($sformatf("enc_r%0d", 12 + i), mem[12 + i], word(CT, i));
      load_pt(CT);
      issue(5'd4, 5'd8, 5'd16, 1'b1, MINLAT); wait_done();
      for (int unsigned i = 0; i < 4; i++) chk($sformatf("dec_r%0d", 16 + i), mem[16 + i], word(PT, i));

      // destination wraps through x0
      load_pt(PT);
      issue(5'd4, 5'd8, 5'd30, 1'b0, MINLAT); wait_done();
      chk("wrap_r30", mem[30], word(CT, 0));
      chk("wrap_r31", mem[31], word(CT, 1));
      chk("wrap_r0", mem[0], 32'h0);
      chk("wrap_r1", mem[1], word(CT, 3));

      // grant toggling every cycle
      for (int unsigned i = 0; i < 4; i++) poke(5'(12 + i), 32'h0);
      gnt_mode = 1;
      issue(5'd4, 5'd8, 5'd12, 1'b0, 0); wait_done();
      for (int unsigned i = 0; i < 4; i++) chk($sformatf("toggle_r%0d", 12 + i), mem[12 + i], word(CT, i));
      gnt_mode = 0;

      // second start while running is ignored
      n0 = done_seen;
      issue(5'd20, 5'd24, 5'd2, 1'b1, MINLAT);
      repeat (15) @(posedge CLK_DC);
      @(negedge CLK_DC);
      start = 1'b1; mode = 1'b0; src_base = 5'd9; key_base = 5'd3; dst_base = 5'd25;
      chk("busy_during_run", busy, 1'b1);
      @(posedge CLK_DC); #1; start = 1'b0;
      wait_done();
      repeat (60) @(posedge CLK_DC);
      chk("single_done", done_seen - n0, 1);

      // reset in WRITE after two writes
      n0 = wr_seen; g = 0;
      issue(5'd4, 5'd8, 5'd20, 1'b0, MINLAT);
      while (wr_seen < n0 + 2 && g < 200) begin
         @(posedge CLK_DC); #2; g++;
      end
      chk("two_writes_before_reset", wr_seen - n0, 2);
      RST = 1'b0; #1;
      chk("midreset_ctrl", {reg_req, ra, wa, wd, we, aes_sel_inv, busy, done, stall}, '0);
      chk("midreset_aes_data", aes_data, '0);
      exp_wr.delete(); exp_dn.delete();
      for (int unsigned i = 2; i < 4; i++) if (last_a[i] != 5'd0) shadow[last_a[i]] = last_v[i];
      repeat (3) @(posedge CLK_DC);
      @(negedge CLK_DC); RST = 1'b1;
      repeat (30) @(posedge CLK_DC);
      issue(5'd4, 5'd8, 5'd12, 1'b0, MINLAT); wait_done();

      // randomized operations with overlapping operands
      for (int unsigned n = 0; n < 12; n++) begin
         poke(5'($urandom_range(1, 31)), $urandom);
         poke(5'($urandom_range(1, 31)), $urandom);
         gnt_mode = (n % 2 == 0) ? 0 : 2;
         issue(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), (gnt_mode == 0) ? MINLAT : 0);
         wait_done();
      end
      gnt_mode = 0;
      repeat (5) @(posedge CLK_DC);

      for (int unsigned i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), mem[i], shadow[i]);
      chk("queues_empty", exp_wr.size() + exp_dn.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_reg_sequencer.md
Name: aes_reg_sequencer

Overview:
- Controller that runs one AES-128 operation using operands held in the general register file.
- On a start command it does the following in order:
  - takes ownership of the register-file read/write ports;
  - reads 4 plaintext/cipher words and 4 key words;
  - drives the AES/invAES core and waits its fixed latency;
  - writes the 4 result words back to the register file.
- Sits between the decode/execute control and the register file. It stalls the core pipeline while it owns the ports.

Parameters:
- AES_LATENCY, 12: CLK_DC cycles from operand presentation to a stable core result (range 1..255).
- REG_AW, 5: register address width (32 registers).

Ports:
- RST, in, 1: reset, asynchronous, active-low.
- CLK_DC, in, 1: clock.
- start, in, 1: single-cycle command pulse; sampled only in IDLE.
- mode, in, 1: 0 = encrypt (aes), 1 = decrypt (invAes); latched at start.
- src_base, in, 5: first register of the 4-word data operand.
- key_base, in, 5: first register of the 4-word key.
- dst_base, in, 5: first register of the 4-word result.
- reg_req, out, 1: request for register-file port ownership.
- reg_gnt, in, 1: ownership grant from the pipeline arbiter.
- ra, out, 5: read address to the register file.
- rd, in, 32: read data; valid the cycle after ra is driven (registered read).
- wa, out, 5: write address.
- wd, out, 32: write data.
- we, out, 1: write enable.
- aes_data, out, 128: operand to the core.
- aes_key, out, 128: key to the core.
- aes_sel_inv, out, 1: selects the invAes result.
- aes_result, in, 128: core output.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when the last write completes.
- stall, out, 1: equals reg_req.

Behaviour:
- Reset (async, RST low):
  - State returns to IDLE.
  - All outputs go to 0: reg_req, ra, wa, wd, we, aes_data, aes_key, aes_sel_inv, busy, done.
  - Counters and latched bases are cleared.
  - Reset mid-operation abandons the operation with no further writes.
- Word order: register base+i maps to bits [127-32i : 96-32i] (word 0 = MSB).
- Register addresses are base+i modulo 32, so they wrap 31 -> 0.
- IDLE:
  - On start=1: latch mode, src_base, key_base and dst_base; set reg_req=1; go to WAIT_GNT.
  - start while busy is ignored. No queueing.
- WAIT_GNT: stay until reg_gnt=1, then go to LOAD with count=0.
- LOAD (8 reads: src+0..3 then key+0..3):
  - Each granted cycle with count<8: drive ra = address(count), set rd_pend=1, count++.
  - The cycle after each issue: capture rd into the corresponding aes_data/aes_key word.
  - Once count=8 and the final capture is done (9 cycles with a continuous grant), go to RUN.
  - aes_data/aes_key update only during LOAD and then hold until the next start.
- RUN:
  - reg_req drops to 0, so the pipeline may proceed.
  - Wait exactly AES_LATENCY cycles, then latch aes_result into an internal 128-bit result register.
  - Raise reg_req and go to WAIT_GNT2.
- WAIT_GNT2: stay until reg_gnt=1.
- WRITE:
  - Each granted cycle: we=1, wa=dst_base+i, wd=result word i, for i=0..3.
  - When the target address is 0, we is forced to 0 for that word, but the cycle is still consumed.
- DONE:
  - Lasts 1 cycle: done=1, reg_req=0.
  - Return to IDLE. busy falls in the cycle after DONE.
- Grant loss during LOAD/WRITE (reg_gnt=0):
  - No new read is issued and no write occurs (we=0); the count holds.
  - A read already in flight is still captured the next cycle.
  - Work resumes when reg_gnt returns.
- Overlaps: operands may overlap each other, or dst may overlap src/key. Reads complete before any write, so results are always computed from the pre-operation values.
- aes_sel_inv = latched mode, held constant from start to DONE.
- Minimum total latency with a continuous grant: 1 + 9 + AES_LATENCY + 1 + 4 + 1 cycles from start to done.

Test Plan:
- Encrypt:
  - Stimulus: r4..r7 = 00112233_44556677_8899aabb_ccddeeff; r8..r11 = 00010203_04050607_08090a0b_0c0d0e0f; start with mode=0, src=4, key=8, dst=12; grant tied high.
  - Response: r12..r15 = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a; done pulses exactly once, 28 cycles after start.
- Decrypt: same key, r4..r7 = that cipher, mode=1, dst=16 -> r16..r19 = 00112233_44556677_8899aabb_ccddeeff.
- Wrap and x0:
  - Stimulus: dst_base=30.
  - Response: writes go to 30, 31, then 0 with we=0, then 1; r0 stays 0.
- Grant toggling: reg_gnt toggles every cycle during LOAD and WRITE -> the same results as the first scenario, with no duplicated or missing ra/wa addresses.
- Busy start: a second start pulse in the RUN state -> ignored; exactly one done pulse.
- Reset mid-operation: RST low in WRITE after 2 writes -> all outputs 0 immediately; no further we pulses; the next start completes normally.
